// File: rtl/blake2b_round_ctrl_if.sv
// Job and G-mix bus between the miner front end, the round sequencer
// and the shared mix datapath.
interface blake2b_round_ctrl_if;
  logic          start;
  logic [511:0]  h_in;
  logic [1023:0] m_in;
  logic [127:0]  t_in;
  logic          f_in;
  logic          busy;
  logic          done;
  logic [511:0]  h_out;
  logic [63:0]   mix_a;
  logic [63:0]   mix_b;
  logic [63:0]   mix_c;
  logic [63:0]   mix_d;
  logic [63:0]   mix_x;
  logic [63:0]   mix_y;
  logic [63:0]   mix_ra;
  logic [63:0]   mix_rb;
  logic [63:0]   mix_rc;
  logic [63:0]   mix_rd;

  modport slave (
    input  start, h_in, m_in, t_in, f_in,
    input  mix_ra, mix_rb, mix_rc, mix_rd,
    output busy, done, h_out,
    output mix_a, mix_b, mix_c, mix_d, mix_x, mix_y
  );

  modport master (
    output start, h_in, m_in, t_in, f_in,
    output mix_ra, mix_rb, mix_rc, mix_rd,
    input  busy, done, h_out,
    input  mix_a, mix_b, mix_c, mix_d, mix_x, mix_y
  );
endinterface

// File: rtl/blake2b_round_ctrl.sv
// BLAKE2b compression sequencer: owns v and the message schedule and
// drives one shared G-mix datapath whose results return a cycle later.
module blake2b_round_ctrl #(
  parameter int ROUNDS = 12
) (
  input logic                 clk,
  input logic                 rst,
  blake2b_round_ctrl_if.slave bus
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // nibble j of row r is sigma[r][j]
  localparam logic [63:0] SIGMA [10] = '{
    64'hFEDCBA9876543210, 64'h357B20C16DF984AE,
    64'h491763EADF250C8B, 64'h8F04A562EBCD1397,
    64'hD386CB1EFA427509, 64'h91EF57D438B0A6C2,
    64'hB8293670A4DEF15C, 64'hA2684F05931CE7BD,
    64'h5A417D2C803B9EF6, 64'h0DC3E9BF5167482A
  };

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COL, S_CBUB,
    S_DIAG, S_DBUB, S_FINAL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_k;
  logic [RW-1:0]   r_round;
  logic [3:0]      r_srow;
  logic [63:0]     r_v [16];
  logic [63:0]     r_m [16];
  logic [63:0]     r_h [8];
  logic [127:0]    r_t;
  logic            r_f;
  logic            r_wb_vld;
  logic [2:0]      r_wb_tag;
  logic [511:0]    r_hout;
  logic            r_done;

  logic            w_issue;
  logic            w_accept;
  logic [2:0]      w_step;
  logic [15:0]     w_idx;
  logic [15:0]     w_wb_idx;
  logic [63:0]     w_sig;
  logic [3:0]      w_sx;
  logic [3:0]      w_sy;

  // {d,c,b,a} word indices of G step s
  function automatic logic [15:0] g_idx(input logic [2:0] s);
    logic [1:0] j;
    j = s[1:0];
    if (!s[2])
      g_idx = {2'd3, j, 2'd2, j, 2'd1, j, 2'd0, j};
    else
      g_idx = {2'd3, j + 2'd3, 2'd2, j + 2'd2,
               2'd1, j + 2'd1, 2'd0, j};
  endfunction

  always_comb begin
    w_issue  = (r_state == S_COL) || (r_state == S_DIAG);
    w_accept = (r_state == S_IDLE) && bus.start;
    w_step   = {r_state == S_DIAG, r_k};
    w_idx    = g_idx(w_step);
    w_wb_idx = g_idx(r_wb_tag);
    w_sig    = SIGMA[r_srow];
    w_sx     = w_sig[{w_step, 3'b000} +: 4];
    w_sy     = w_sig[{w_step, 3'b100} +: 4];
  end

  always_comb begin
    bus.mix_a = '0;
    bus.mix_b = '0;
    bus.mix_c = '0;
    bus.mix_d = '0;
    bus.mix_x = '0;
    bus.mix_y = '0;
    if (w_issue) begin
      bus.mix_a = r_v[w_idx[3:0]];
      bus.mix_b = r_v[w_idx[7:4]];
      bus.mix_c = r_v[w_idx[11:8]];
      bus.mix_d = r_v[w_idx[15:12]];
      bus.mix_x = r_m[w_sx];
      bus.mix_y = r_m[w_sy];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LOAD;
      S_LOAD:  w_next = S_COL;
      S_COL:   if (r_k == 2'd3) w_next = S_CBUB;
      S_CBUB:  w_next = S_DIAG;
      S_DIAG:  if (r_k == 2'd3) w_next = S_DBUB;
      S_DBUB:  w_next = (r_round == LAST) ? S_FINAL : S_COL;
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k      <= '0;
      r_round  <= '0;
      r_srow   <= '0;
      r_wb_vld <= 1'b0;
      r_wb_tag <= '0;
      r_done   <= 1'b0;
      r_hout   <= '0;
      r_t      <= '0;
      r_f      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_v[i] <= '0;
        r_m[i] <= '0;
      end
      for (int i = 0; i < 8; i++) r_h[i] <= '0;
    end else begin
      r_wb_vld <= w_issue;
      r_wb_tag <= w_step;
      r_done   <= (r_state == S_FINAL);
      if (w_accept) begin
        for (int j = 0; j < 16; j++)
          r_m[j] <= bus.m_in[64*j +: 64];
        for (int i = 0; i < 8; i++)
          r_h[i] <= bus.h_in[64*i +: 64];
        r_t <= bus.t_in;
        r_f <= bus.f_in;
      end
      if (r_state == S_LOAD) begin
        for (int i = 0; i < 8; i++) begin
          r_v[i]   <= r_h[i];
          r_v[i+8] <= IV[i];
        end
        r_v[12] <= IV[4] ^ r_t[63:0];
        r_v[13] <= IV[5] ^ r_t[127:64];
        r_v[14] <= r_f ? ~IV[6] : IV[6];
        r_k     <= '0;
        r_round <= '0;
        r_srow  <= '0;
      end
      // results of the step issued last cycle land at this edge
      if (r_wb_vld) begin
        r_v[w_wb_idx[3:0]]   <= bus.mix_ra;
        r_v[w_wb_idx[7:4]]   <= bus.mix_rb;
        r_v[w_wb_idx[11:8]]  <= bus.mix_rc;
        r_v[w_wb_idx[15:12]] <= bus.mix_rd;
      end
      if (w_issue) r_k <= r_k + 2'd1;
      if (r_state == S_DBUB) begin
        r_round <= r_round + RW'(1);
        r_srow  <= (r_srow == 4'd9) ? 4'd0 : r_srow + 4'd1;
      end
      if (r_state == S_FINAL) begin
        for (int i = 0; i < 8; i++)
          r_hout[64*i +: 64] <= r_h[i] ^ r_v[i] ^ r_v[i+8];
      end
    end
  end

  // busy rises with the first issue cycle and covers the done cycle
  assign bus.busy  = !((r_state == S_IDLE) || (r_state == S_LOAD))
                     || r_done;
  assign bus.done  = r_done;
  assign bus.h_out = r_hout;

endmodule

// File: tb/tb_blake2b_round_ctrl.sv
// Scoreboard bench for blake2b_round_ctrl with a behavioural G-mix
// datapath and a reference BLAKE2b compression function.
module tb_blake2b_round_ctrl;

  localparam int R   = 12;
  localparam int LAT = 10 * R + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          n_chk = 0;
  int          n_err = 0;

  blake2b_round_ctrl_if bus();

  blake2b_round_ctrl #(.ROUNDS(R)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  int sig [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  int gi [8][4] = '{
    '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
  };

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [255:0] gmix(
    input logic [63:0] a, b, c, d, x, y);
    a = a + b + x;  d = ror(d ^ a, 32);
    c = c + d;      b = ror(b ^ c, 24);
    a = a + b + y;  d = ror(d ^ a, 16);
    c = c + d;      b = ror(b ^ c, 63);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_f(
    input logic [511:0] h, input logic [1023:0] m,
    input logic [127:0] t, input logic f);
    logic [63:0]  v  [16];
    logic [63:0]  mm [16];
    logic [255:0] q;
    logic [511:0] o;
    int           row;
    for (int i = 0; i < 16; i++) mm[i] = m[64*i +: 64];
    for (int i = 0; i < 8; i++) begin
      v[i]   = h[64*i +: 64];
      v[i+8] = IV[i];
    end
    v[12] ^= t[63:0];
    v[13] ^= t[127:64];
    if (f) v[14] = ~v[14];
    for (int r = 0; r < R; r++) begin
      row = r % 10;
      for (int s = 0; s < 8; s++) begin
        q = gmix(v[gi[s][0]], v[gi[s][1]], v[gi[s][2]], v[gi[s][3]],
                 mm[sig[row][2*s]], mm[sig[row][2*s+1]]);
        v[gi[s][0]] = q[255:192];
        v[gi[s][1]] = q[191:128];
        v[gi[s][2]] = q[127:64];
        v[gi[s][3]] = q[63:0];
      end
    end
    for (int i = 0; i < 8; i++)
      o[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i+8];
    return o;
  endfunction

  // behavioural mix datapath: registered G step
  logic [255:0] mix_q = '0;
  always @(posedge clk)
    mix_q <= gmix(bus.mix_a, bus.mix_b, bus.mix_c,
                  bus.mix_d, bus.mix_x, bus.mix_y);
  assign bus.mix_ra = mix_q[255:192];
  assign bus.mix_rb = mix_q[191:128];
  assign bus.mix_rc = mix_q[127:64];
  assign bus.mix_rd = mix_q[63:0];

  task automatic chk(input string tag,
                     input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [511:0] h;
    int unsigned  due;
  } exp_t;

  exp_t         sb [$];
  exp_t         mon_e;
  logic [511:0] last_hout = '0;

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 512'(bus.done), 512'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("h_out", bus.h_out, mon_e.h);
        chk("done_cycle", 512'(cyc), 512'(mon_e.due));
        last_hout = bus.h_out;
      end
    end
  end

  task automatic launch(input logic [511:0] h, input logic [1023:0] m,
                        input logic [127:0] t, input logic f);
    bus.h_in  = h;
    bus.m_in  = m;
    bus.t_in  = t;
    bus.f_in  = f;
    bus.start = 1'b1;
    sb.push_back('{ref_f(h, m, t, f), cyc + LAT + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 512'(sb.size()), 512'(0));
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [1023:0] rnd_bits();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d expected below 20000", cyc);
    $fatal(1, "watchdog");
  end

  logic [511:0]  h_abc;
  logic [1023:0] m_abc;
  logic [511:0]  h1, h2, rh;
  logic [1023:0] rm, rall;
  logic [127:0]  rt;
  int            busy_cnt;
  int unsigned   due3;

  initial begin
    bus.start = 1'b0;
    bus.h_in  = '0;
    bus.m_in  = '0;
    bus.t_in  = '0;
    bus.f_in  = 1'b0;
    for (int i = 0; i < 8; i++) h_abc[64*i +: 64] = IV[i];
    h_abc[63:0] ^= 64'h01010040;
    m_abc = '0;
    m_abc[63:0] = 64'h636261;

    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(bus.busy), 512'(0));
    chk("rst_done", 512'(bus.done), 512'(0));
    chk("rst_hout", bus.h_out, 512'(0));
    chk("rst_mix", 512'({bus.mix_a, bus.mix_b, bus.mix_x}), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    launch(h_abc, m_abc, 128'd3, 1'b1);
    wait_drain(LAT + 20);
    chk("abc_h0", 512'(last_hout[63:0]), 512'(64'h0D4D1C983FA580BA));
    h1 = last_hout;

    launch(h_abc, m_abc, 128'd3, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
    end
    wait_drain(20);
    h2 = last_hout;
    chk("busy_len", 512'(busy_cnt), 512'(LAT));
    chk("f_changes_h", 512'(h2 != h1), 512'(1));
    repeat (5) @(negedge clk);
    chk("h_out_hold", bus.h_out, h2);

    rall = rnd_bits();
    rh   = rall[511:0];
    rm   = rnd_bits();
    rt   = rall[639:512];
    launch(rh, rm, rt, 1'b0);
    @(negedge clk);
    chk("g0_a", 512'(bus.mix_a), 512'(rh[63:0]));
    chk("g0_b", 512'(bus.mix_b), 512'(rh[319:256]));
    chk("g0_c", 512'(bus.mix_c), 512'(IV[0]));
    chk("g0_d", 512'(bus.mix_d), 512'(IV[4] ^ rt[63:0]));
    chk("g0_xy", 512'({bus.mix_x, bus.mix_y}), 512'({rm[63:0], rm[127:64]}));
    @(negedge clk);
    chk("g1_a", 512'(bus.mix_a), 512'(rh[127:64]));
    chk("g1_xy", 512'({bus.mix_x, bus.mix_y}), 512'({rm[191:128], rm[255:192]}));
    repeat (3) @(negedge clk);
    chk("cbub_zero", 512'({bus.mix_a, bus.mix_b, bus.mix_c,
                           bus.mix_d, bus.mix_x, bus.mix_y}), 512'(0));
    @(negedge clk);
    chk("g4_xy", 512'({bus.mix_x, bus.mix_y}), 512'({rm[575:512], rm[639:576]}));
    repeat (4) @(negedge clk);
    chk("dbub_zero", 512'({bus.mix_a, bus.mix_b, bus.mix_c,
                           bus.mix_d, bus.mix_x, bus.mix_y}), 512'(0));
    @(negedge clk);
    chk("r1_g0_xy", 512'({bus.mix_x, bus.mix_y}), 512'({rm[959:896], rm[703:640]}));
    wait_drain(LAT + 20);

    rall = rnd_bits();
    rm   = rnd_bits();
    bus.h_in  = rall[511:0];
    bus.m_in  = rm;
    bus.t_in  = rall[639:512];
    bus.f_in  = 1'b1;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++)
      sb.push_back('{ref_f(rall[511:0], rm, rall[639:512], 1'b1),
                     cyc + LAT + 1 + k * (LAT + 1)});
    due3 = cyc + LAT + 1 + 2 * (LAT + 1);
    for (int i = 0; i < 3 * (LAT + 1) + 20 && cyc < due3; i++)
      @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_drain", 512'(sb.size()), 512'(0));
    chk("b2b_idle", 512'(bus.busy), 512'(0));
    sb.delete();

    rall = rnd_bits();
    launch(rall[511:0], rnd_bits(), rall[639:512], 1'b0);
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 512'(bus.busy), 512'(0));
    chk("mid_rst_done", 512'(bus.done), 512'(0));
    chk("mid_rst_hout", bus.h_out, 512'(0));
    chk("mid_rst_mix", 512'({bus.mix_a, bus.mix_d}), 512'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(h_abc, m_abc, 128'd3, 1'b1);
    wait_drain(LAT + 20);
    chk("restart_abc", last_hout, h1);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
